ascon_decrypt_core: RTL and testbench
=====================================

# ascon_decrypt_core

Iterative ASCON-128 single-block authenticated-decryption engine. It is the receive-side counterpart of the encryption path built around the 320-bit `permutation` block. It takes key, nonce, an optional pre-padded 64-bit associated-data block, one full 64-bit ciphertext block and a 128-bit tag. It returns the plaintext and a tag-match flag. One permutation round is computed per clock by an internal round function; the block does not instantiate `permutation`.

## Interface
Parameters:
- `IV`, 64'h80400c0600000000, ASCON-128 initialisation vector.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin an operation; sampled only while idle.
- `key`  in  128  secret key K; must be held stable start→done.
- `nonce`  in  128  nonce N; captured on the accepted start.
- `ad`  in  64  associated-data block, already padded by the host; captured on start.
- `ad_en`  in  1  1 = process the `ad` block, 0 = no AD; captured on start.
- `ct`  in  64  ciphertext block C (full 64 bits); captured on start.
- `tag_in`  in  128  received tag; captured on start.
- `pt`  out  64  recovered plaintext.
- `busy`  out  1  high from the accepted start until done.
- `done`  out  1  one-cycle pulse at the end of the operation.
- `tag_ok`  out  1  computed tag equals `tag_in`; valid from done until the next start.

## Operation
- State S = S0..S4, 64 bits each; S0 is the MSB word.
- Round (constant index r): S2 ^= {56'b0, (4'hF−r), r[3:0]}; then the 5-bit ASCON S-box, bit-sliced across the words; then linear layer:
  - S0 ^= ror19 ^ ror28
  - S1 ^= ror61 ^ ror39
  - S2 ^= ror1 ^ ror6
  - S3 ^= ror10 ^ ror17
  - S4 ^= ror7 ^ ror41
- Constant index: p12 uses r = 0..11; p6 uses r = 6..11.
- FSM states and actions:
  - IDLE: on start, load S = IV‖K‖N, capture inputs, go INIT.
  - INIT: p12. Then S3‖S4 ^= K. If ad_en, S0 ^= ad and go AD. Otherwise S4 ^= 1 and go CT.
  - AD: p6. Then S4 ^= 1, go CT.
  - CT: on entry, pt ← S0 ^ C, then S0 ← C. Run p6. Then S0 ^= 64'h8000_0000_0000_0000 (padding block of an empty final message), S1‖S2 ^= K, go FINAL.
  - FINAL: p12. Then T = (S3‖S4) ^ K; tag_ok ← (T == tag_in); done ← 1; go IDLE.
- Inter-phase XORs are applied combinationally on the output of the last round of a phase; they cost no extra cycle.
- A 4-bit round counter counts rounds and wraps to 0 at each phase change.
- start while busy: ignored. start in the cycle done is high: accepted (FSM is already in IDLE).

## Timing
- Edge E0 samples start. The load happens at E0 and busy is high after E0.
- Each following edge executes one round.
- done is high for exactly one cycle:
  - after edge E31 when ad_en=0 (12 + 6 + 12 rounds, plus the register-in cycle);
  - after edge E37 when ad_en=1.
- busy falls in the same cycle that done rises.
- pt is registered on the CT-entry edge and held until the next accepted start.
- Reset values: pt=0, busy=0, done=0, tag_ok=0, S=0, FSM=IDLE, counter=0.
- rst mid-operation aborts the operation on that edge; all outputs return to reset values, and no done is produced.

## Configuration
- `ASCON_PT_GATE_EN` defined:
  - `pt` reads 0 until done with tag_ok=1, then shows the plaintext.
  - A tag failure keeps `pt` at 0.
  - `pt` is cleared on the next accepted start.
- Undefined: `pt` is visible from the CT-entry edge regardless of the tag outcome.

## Test plan
- **Permutation check:** force S = 320'h80400c0600000000c82cbe1c72be1a3a85621d92797f847523fd6519897d9e125c0609b2f5ca3aaa (K = c82c…8475, N = 23fd…3aaa). Compare S after INIT p12 against the golden model, word by word.
- **Golden decrypt, no AD:** K and N as above, ad_en=0, (C, tag) from the golden encryptor with P=64'h0001020304050607 → done at E31, pt=64'h0001020304050607, tag_ok=1.
- **Golden decrypt with AD:** same inputs, ad_en=1, ad=64'h0011223344556677 → done at E37, tag_ok=1. Flip tag_in bit 0 → tag_ok=0; with `ASCON_PT_GATE_EN`, pt=0.
- **start pulsed at E5 while busy** → ignored; single done at E31; results unchanged.
- **rst asserted at E10** → busy=0, pt=0, tag_ok=0 next cycle; no done. A fresh start afterwards completes normally.
- **Back-to-back:** start asserted in the done cycle → accepted; second done exactly 31 cycles later.

Source files
------------

// File: rtl/ascon_decrypt_core.sv
// Iterative ASCON-128 single-block authenticated decryption, one round per clock.
// Optional define ASCON_PT_GATE_EN: plaintext reads 0 unless the tag verified.
module ascon_decrypt_core #(
  parameter logic [63:0] IV = 64'h80400c0600000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [63:0]  ad,
  input  logic         ad_en,
  input  logic [63:0]  ct,
  input  logic [127:0] tag_in,
  output logic [63:0]  pt,
  output logic         busy,
  output logic         done,
  output logic         tag_ok
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_AD    = 3'd2;
  localparam logic [2:0] S_CT    = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;

  // NOTE: blocking assignments are correct here; a function body is plain combinational dataflow.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
    x2 = x2 ^ {56'b0, 4'hF - r, r};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x0, x1, x2, x3, x4};
  endfunction

  logic [2:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [319:0] s_q, s_d;
  logic [63:0]  ad_q, ad_d, ct_q, ct_d, pt_q, pt_d;
  logic [127:0] tag_q, tag_d;
  logic         ad_en_q, ad_en_d, busy_q, busy_d, done_q, done_d, tag_ok_q, tag_ok_d;
  logic         pt_vis_q, pt_vis_d;
  logic [3:0]   rnd_idx;
  logic         last_rnd, tag_match;
  logic [319:0] s_rnd;

  // CT spends its first cycle (cnt 0) absorbing the ciphertext, so its rounds sit at cnt 1..6.
  always_comb begin
    rnd_idx  = cnt_q;
    last_rnd = (cnt_q == 4'd11);
    if (state_q == S_AD) begin
      rnd_idx  = cnt_q + 4'd6;
      last_rnd = (cnt_q == 4'd5);
    end else if (state_q == S_CT) begin
      rnd_idx  = cnt_q + 4'd5;
      last_rnd = (cnt_q == 4'd6);
    end
  end

  assign s_rnd     = ascon_round(s_q, rnd_idx);
  assign tag_match = ((s_rnd[127:0] ^ key) == tag_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    ad_d     = ad_q;
    ad_en_d  = ad_en_q;
    ct_d     = ct_q;
    tag_d    = tag_q;
    pt_d     = pt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tag_ok_d = tag_ok_q;
    pt_vis_d = pt_vis_q;
    case (state_q)
      S_IDLE: if (start) begin
        s_d      = {IV, key, nonce};
        ad_d     = ad;
        ad_en_d  = ad_en;
        ct_d     = ct;
        tag_d    = tag_in;
        pt_d     = '0;
        tag_ok_d = 1'b0;
        pt_vis_d = 1'b0;
        busy_d   = 1'b1;
        cnt_d    = '0;
        state_d  = S_INIT;
      end
      S_INIT: begin
        s_d   = s_rnd;
        cnt_d = cnt_q + 4'd1;
        if (last_rnd) begin
          cnt_d          = '0;
          s_d[127:0]     = s_rnd[127:0] ^ key;
          if (ad_en_q) begin
            s_d[319:256] = s_rnd[319:256] ^ ad_q;
            state_d      = S_AD;
          end else begin
            s_d[0]       = ~s_d[0];
            state_d      = S_CT;
          end
        end
      end
      S_AD: begin
        s_d   = s_rnd;
        cnt_d = cnt_q + 4'd1;
        if (last_rnd) begin
          cnt_d   = '0;
          s_d[0]  = ~s_rnd[0];
          state_d = S_CT;
        end
      end
      S_CT: begin
        if (cnt_q == 4'd0) begin
          pt_d         = s_q[319:256] ^ ct_q;
          s_d[319:256] = ct_q;
          cnt_d        = 4'd1;
        end else begin
          s_d   = s_rnd;
          cnt_d = cnt_q + 4'd1;
          if (last_rnd) begin
            cnt_d        = '0;
            s_d[319:256] = s_rnd[319:256] ^ 64'h8000_0000_0000_0000;
            s_d[255:128] = s_rnd[255:128] ^ key;
            state_d      = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        s_d   = s_rnd;
        cnt_d = cnt_q + 4'd1;
        if (last_rnd) begin
          cnt_d    = '0;
          tag_ok_d = tag_match;
          pt_vis_d = tag_match;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the wide state register is reset as well, because S=0 is part of the defined reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      s_q      <= '0;
      ad_q     <= '0;
      ad_en_q  <= 1'b0;
      ct_q     <= '0;
      tag_q    <= '0;
      pt_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tag_ok_q <= 1'b0;
      pt_vis_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      ad_q     <= ad_d;
      ad_en_q  <= ad_en_d;
      ct_q     <= ct_d;
      tag_q    <= tag_d;
      pt_q     <= pt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tag_ok_q <= tag_ok_d;
      pt_vis_q <= pt_vis_d;
    end
  end

`ifdef ASCON_PT_GATE_EN
  assign pt = pt_vis_q ? pt_q : '0;
`else
  assign pt = pt_q;
  logic unused_vis;
  assign unused_vis = pt_vis_q;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign tag_ok = tag_ok_q;

endmodule

// File: tb/tb_ascon_decrypt_core.sv
// Self-checking bench for ascon_decrypt_core: table-driven vectors, scoreboard and
// hand-written corner sequences, checked against an independent table-based ASCON model.
module tb_ascon_decrypt_core;

  localparam logic [63:0]  IV = 64'h80400c0600000000;
  localparam logic [127:0] K0 = 128'hc82cbe1c72be1a3a85621d92797f8475;
  localparam logic [127:0] N0 = 128'h23fd6519897d9e125c0609b2f5ca3aaa;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] N1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  typedef struct {
    logic         ad_en;
    logic [63:0]  ad;
    logic [63:0]  p;
    logic [127:0] key;
    logic [127:0] nonce;
    logic         flip;
  } vec_t;

  typedef struct {
    logic [63:0] pt;
    logic        tag_ok;
    int          done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, ad_en;
  logic [127:0] key, nonce, tag_in;
  logic [63:0]  ad, ct, pt;
  logic         busy, done, tag_ok;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  exp_t sb[$];
  vec_t vecs[5];

  ascon_decrypt_core dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce), .ad(ad),
    .ad_en(ad_en), .ct(ct), .tag_in(tag_in), .pt(pt), .busy(busy), .done(done),
    .tag_ok(tag_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  function automatic logic [63:0] ror(input logic [63:0] w, input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  function automatic logic [319:0] tb_perm(input logic [319:0] s_in, input int r0);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v, o;
    for (int k = 0; k < 5; k++) x[k] = s_in[319-64*k -: 64];
    for (int r = r0; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int i = 0; i < 64; i++) begin
        v = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
        o = SBOX[v];
        for (int k = 0; k < 5; k++) y[k][i] = o[4-k];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // Reference encryptor for a single full 64-bit message block.
  task automatic enc(input vec_t v, output logic [63:0] c, output logic [127:0] t);
    logic [319:0] s;
    s = tb_perm({IV, v.key, v.nonce}, 0);
    s[127:0] = s[127:0] ^ v.key;
    if (v.ad_en) begin
      s[319:256] = s[319:256] ^ v.ad;
      s = tb_perm(s, 6);
    end
    s[63:0] = s[63:0] ^ 64'd1;
    s[319:256] = s[319:256] ^ v.p;
    c = s[319:256];
    s = tb_perm(s, 6);
    s[319:256] = s[319:256] ^ 64'h8000_0000_0000_0000;
    s[255:128] = s[255:128] ^ v.key;
    s = tb_perm(s, 0);
    t = s[127:0] ^ v.key;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; the next edge is E0 of the new operation.
  task automatic start_op(input vec_t v);
    logic [63:0]  c;
    logic [127:0] t;
    exp_t         e;
    enc(v, c, t);
    key    = v.key;
    nonce  = v.nonce;
    ad     = v.ad;
    ad_en  = v.ad_en;
    ct     = c;
    tag_in = v.flip ? (t ^ 128'd1) : t;
`ifdef ASCON_PT_GATE_EN
    e.pt = v.flip ? 64'd0 : v.p;
`else
    e.pt = v.p;
`endif
    e.tag_ok   = ~v.flip;
    e.done_cyc = cyc + 1 + (v.ad_en ? 37 : 31);
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Scoreboard: each done pops one expected result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", done, 0);
      else begin
        e = sb.pop_front();
        check("pt", pt, e.pt);
        check("tag_ok", tag_ok, e.tag_ok);
        check("done_cycle", cyc, e.done_cyc);
        check("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    logic [319:0] s_exp;
    int n;
    vecs[0] = '{ad_en: 1'b0, ad: 64'h0, p: 64'h0001020304050607, key: K0, nonce: N0, flip: 1'b0};
    vecs[1] = '{ad_en: 1'b1, ad: 64'h0011223344556677, p: 64'h0001020304050607, key: K0, nonce: N0, flip: 1'b0};
    vecs[2] = '{ad_en: 1'b1, ad: 64'h0011223344556677, p: 64'h0001020304050607, key: K0, nonce: N0, flip: 1'b1};
    vecs[3] = '{ad_en: 1'b0, ad: 64'h0, p: 64'hdeadbeefcafef00d, key: K1, nonce: N1, flip: 1'b0};
    vecs[4] = '{ad_en: 1'b1, ad: 64'h8000000000000000, p: 64'hffffffffffffffff, key: K1, nonce: N1, flip: 1'b1};

    rst = 1'b1; start = 1'b0; key = '0; nonce = '0; ad = '0; ad_en = 1'b0; ct = '0; tag_in = '0;
    repeat (3) tick();
    check("rst_pt", pt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tag_ok", tag_ok, 0);
    check("rst_state", dut.s_q, 0);
    rst = 1'b0;
    tick();

    // State after INIT p12 plus the key/domain XORs, word by word.
    start_op(vecs[0]);
    repeat (12) tick();
    s_exp = tb_perm({IV, K0, N0}, 0);
    s_exp[127:0] = s_exp[127:0] ^ K0;
    s_exp[0] = ~s_exp[0];
    for (int k = 0; k < 5; k++) check($sformatf("perm_s%0d", k), dut.s_q[319-64*k -: 64], s_exp[319-64*k -: 64]);
    drain(60);
    tick();

    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i]);
      drain(60);
      tick();
    end

    // start while busy: asserted for edge E5 with different inputs, must be ignored.
    start_op(vecs[0]);
    repeat (4) tick();
    start = 1'b1; nonce = ~nonce; ct = ~ct; tag_in = ~tag_in;
    tick();
    start = 1'b0;
    check("busy_after_e5", busy, 1);
    drain(60);
    tick();

    // Reset at E10 aborts the operation; no done may follow.
    start_op(vecs[1]);
    repeat (9) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    check("abort_busy", busy, 0);
    check("abort_pt", pt, 0);
    check("abort_tag_ok", tag_ok, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    repeat (45) tick();
    start_op(vecs[1]);
    drain(60);
    tick();

    // Back-to-back: second start in the done cycle.
    start_op(vecs[3]);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check("b2b_first_done", done, 1);
    start_op(vecs[0]);
    drain(60);
    repeat (3) tick();
    check("idle_done_low", done, 0);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
